// File: rtl/loop_interface_pkg.sv
// ---------------------------------------------------------------------------
// loop_interface_pkg
// Shared definitions for the transceiver loop-test interface. The TRX B
// splitter and the TRX A merger both use these constants, so they define the
// loop protocol itself.
//   - link/payload widths and the split point of a payload across two words
//   - one-hot state encoding of the TRX A merge FSM
//   - pad_nonzero(): detects a non-zero pad field in a second link word
// ---------------------------------------------------------------------------
package loop_interface_pkg;

  localparam int LOOP_PAYLOAD_W = 56;  // assembled payload width
  localparam int LOOP_LINK_W    = 34;  // transceiver link word width
  localparam int LOOP_SPLIT     = 22;  // payload bits carried by the second word
  localparam int LOOP_PAD_W     = 12;  // zero pad at the bottom of the second word

  // One-hot state bit positions; the FIFO pop strobe is decoded straight
  // from the two READ bits.
  localparam int ST_IDLE_BIT        = 0;
  localparam int ST_READ_PART_1_BIT = 1;
  localparam int ST_WAIT_PART_2_BIT = 2;
  localparam int ST_READ_PART_2_BIT = 3;
  localparam int ST_WAIT_READY_BIT  = 4;
  localparam int ST_WRITE_BIT       = 5;

  typedef enum logic [5:0] {
    S_IDLE        = 6'(1 << ST_IDLE_BIT),
    S_READ_PART_1 = 6'(1 << ST_READ_PART_1_BIT),
    S_WAIT_PART_2 = 6'(1 << ST_WAIT_PART_2_BIT),
    S_READ_PART_2 = 6'(1 << ST_READ_PART_2_BIT),
    S_WAIT_READY  = 6'(1 << ST_WAIT_READY_BIT),
    S_WRITE       = 6'(1 << ST_WRITE_BIT)
  } merge_state_e;

  function automatic logic pad_nonzero(input logic [LOOP_PAD_W-1:0] pad);
    return |pad;
  endfunction

endpackage

// File: rtl/loop_sat_counter.sv
// ---------------------------------------------------------------------------
// loop_sat_counter
// Event counter for the loop test. Counts inc_i pulses; at all-ones it either
// wraps to zero (SATURATE=0) or holds (SATURATE=1).
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears the count
//   inc_i  : count enable, one increment per cycle high
//   cnt_o  : current count
// ---------------------------------------------------------------------------
module loop_sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(SATURATE && (&cnt_q))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/loop_interface_merge_trx_a.sv
// ---------------------------------------------------------------------------
// loop_interface_merge_trx_a
// Loop-test receive handler for transceiver A. Pops pairs of 34-bit link
// words from a first-word-fall-through FIFO and merges each pair into one
// 56-bit word: the first word is payload[55:22], the second is
// {payload[21:0], 12'h000}. A non-zero pad flags an error but the word is
// still delivered. Word and error counters support the loop test.
//   i_clk, i_arst : clock, asynchronous active-high reset
//   i_trx_valid   : FIFO not empty
//   i_trx         : FIFO head word
//   o_trx_rd      : FIFO pop strobe (one cycle per word)
//   i_data_rdy    : consumer ready, sampled only while waiting to write
//   o_data        : assembled word, held until the next pair completes
//   o_data_wr     : registered one-cycle write strobe
//   o_err_pad     : one-cycle pulse when the second word had a non-zero pad
//   o_word_cnt    : words written, wrapping
//   o_err_cnt     : pad errors, saturating at 255
// ---------------------------------------------------------------------------
module loop_interface_merge_trx_a
  import loop_interface_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_trx_valid,
  input  logic [LOOP_LINK_W-1:0]    i_trx,
  output logic                      o_trx_rd,
  input  logic                      i_data_rdy,
  output logic [LOOP_PAYLOAD_W-1:0] o_data,
  output logic                      o_data_wr,
  output logic                      o_err_pad,
  output logic [15:0]               o_word_cnt,
  output logic [7:0]                o_err_cnt
);

  merge_state_e              state_q;
  merge_state_e              state_d;
  logic [LOOP_LINK_W-1:0]    hi_q;
  logic [LOOP_PAYLOAD_W-1:0] data_q;
  logic                      data_wr_q;
  logic                      err_pad_q;   // one-cycle pulse
  logic                      pad_err_q;   // held until the word is written
  logic                      pad_bad;
  logic                      word_inc;
  logic                      err_inc;

  assign pad_bad = pad_nonzero(i_trx[LOOP_PAD_W-1:0]);

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (i_trx_valid) state_d = S_READ_PART_1;
      S_READ_PART_1: state_d = S_WAIT_PART_2;
      S_WAIT_PART_2: if (i_trx_valid) state_d = S_READ_PART_2;
      S_READ_PART_2: state_d = S_WAIT_READY;
      S_WAIT_READY:  if (i_data_rdy) state_d = S_WRITE;
      S_WRITE:       state_d = S_IDLE;
      default:       state_d = S_IDLE;  // recover from any non-one-hot value
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      data_q    <= '0;
      data_wr_q <= 1'b0;
      err_pad_q <= 1'b0;
      pad_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Registered from next state: high exactly while state_q == S_WRITE.
      data_wr_q <= (state_d == S_WRITE);
      err_pad_q <= (state_q == S_READ_PART_2) && pad_bad;
      if (state_q == S_READ_PART_1) begin
        hi_q <= i_trx;
      end
      if (state_q == S_READ_PART_2) begin
        // Pad bits are dropped; the payload is delivered even when they are bad.
        data_q    <= {hi_q, i_trx[LOOP_LINK_W-1 -: LOOP_SPLIT]};
        pad_err_q <= pad_bad;
      end
    end
  end

  // Decoded straight from state flops, so the pop strobe cannot glitch.
  assign o_trx_rd  = state_q[ST_READ_PART_1_BIT] | state_q[ST_READ_PART_2_BIT];
  assign o_data    = data_q;
  assign o_data_wr = data_wr_q;
  assign o_err_pad = err_pad_q;

  assign word_inc = (state_q == S_WRITE);
  assign err_inc  = word_inc & pad_err_q;

  loop_sat_counter #(
    .WIDTH    (16),
    .SATURATE (1'b0)
  ) u_word_cnt (
    .clk_i (i_clk),
    .rst_i (i_arst),
    .inc_i (word_inc),
    .cnt_o (o_word_cnt)
  );

  loop_sat_counter #(
    .WIDTH    (8),
    .SATURATE (1'b1)
  ) u_err_cnt (
    .clk_i (i_clk),
    .rst_i (i_arst),
    .inc_i (err_inc),
    .cnt_o (o_err_cnt)
  );

endmodule

// File: tb/tb_loop_interface_merge_trx_a.sv
// ---------------------------------------------------------------------------
// tb_loop_interface_merge_trx_a
// Directed bench for the TRX A loop merger. A FWFT FIFO model feeds link
// words; expected payloads are queued when a pair is pushed and compared when
// the DUT raises o_data_wr. Two small counter instances cover wrap and
// saturation of loop_sat_counter directly.
// ---------------------------------------------------------------------------
module tb_loop_interface_merge_trx_a;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic        i_trx_valid;
  logic [33:0] i_trx;
  logic        o_trx_rd;
  logic        i_data_rdy;
  logic [55:0] o_data;
  logic        o_data_wr;
  logic        o_err_pad;
  logic [15:0] o_word_cnt;
  logic [7:0]  o_err_cnt;

  logic        cnt_inc;
  logic [3:0]  wrap_cnt;
  logic [3:0]  sat_cnt;

  int checks   = 0;
  int failures = 0;

  logic [33:0] fifo[$];
  logic [55:0] exp_q[$];

  int rd_seen     = 0;
  int wr_seen     = 0;
  int errpad_seen = 0;
  int words_exp   = 0;
  int cyc         = 0;
  int last_wr     = -1;
  int cad_bad     = 0;
  bit cad_en      = 1'b0;

  always #5 i_clk = ~i_clk;

  loop_interface_merge_trx_a dut (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_trx_valid (i_trx_valid),
    .i_trx       (i_trx),
    .o_trx_rd    (o_trx_rd),
    .i_data_rdy  (i_data_rdy),
    .o_data      (o_data),
    .o_data_wr   (o_data_wr),
    .o_err_pad   (o_err_pad),
    .o_word_cnt  (o_word_cnt),
    .o_err_cnt   (o_err_cnt)
  );

  loop_sat_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap4 (
    .clk_i (i_clk), .rst_i (i_arst), .inc_i (cnt_inc), .cnt_o (wrap_cnt)
  );

  loop_sat_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat4 (
    .clk_i (i_clk), .rst_i (i_arst), .inc_i (cnt_inc), .cnt_o (sat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    i_trx_valid = (fifo.size() != 0);
    i_trx       = (fifo.size() != 0) ? fifo[0] : 34'h0;
  endtask

  task automatic push_word(input logic [33:0] w);
    fifo.push_back(w);
    refresh();
  endtask

  task automatic push_pair(input logic [33:0] p1, input logic [33:0] p2, input logic [55:0] exp);
    fifo.push_back(p1);
    fifo.push_back(p2);
    exp_q.push_back(exp);
    words_exp++;
    refresh();
  endtask

  task automatic wait_wr(input string tag, input int target, input int budget);
    int n = 0;
    while (wr_seen < target && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, 64'(wr_seen >= target), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},     64'(o_data),     64'd0);
    check({tag, "_data_wr"},  64'(o_data_wr),  64'd0);
    check({tag, "_trx_rd"},   64'(o_trx_rd),   64'd0);
    check({tag, "_err_pad"},  64'(o_err_pad),  64'd0);
    check({tag, "_word_cnt"}, 64'(o_word_cnt), 64'd0);
    check({tag, "_err_cnt"},  64'(o_err_cnt),  64'd0);
  endtask

  // Monitor, FIFO pop and scoreboard. Outputs are sampled on the falling
  // edge; a word sampled with o_trx_rd high is popped just after the next
  // rising edge, which is the edge the DUT captured it on.
  initial begin
    logic        pend;
    logic [55:0] exp_w;
    forever begin
      @(negedge i_clk);
      cyc++;
      pend = o_trx_rd;
      if (pend) rd_seen++;
      if (o_err_pad) errpad_seen++;
      if (o_data_wr) begin
        wr_seen++;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("sb_word", 64'(o_data), 64'(exp_w));
        end
        if (cad_en) begin
          if (last_wr >= 0 && (cyc - last_wr) != 6) cad_bad++;
          last_wr = cyc;
        end
      end
      @(posedge i_clk);
      #1;
      if (pend && !i_arst) begin
        if (fifo.size() != 0) void'(fifo.pop_front());
        refresh();
      end
    end
  end

  initial begin
    int          n;
    int          base_rd;
    int          base_wr;
    int          base_ep;
    int          hold_bad;
    logic [33:0] p1;
    logic [21:0] mid;
    logic [11:0] pad;

    i_arst      = 1'b1;
    i_trx_valid = 1'b0;
    i_trx       = 34'h0;
    i_data_rdy  = 1'b1;
    cnt_inc     = 1'b0;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_arst = 1'b0;
    @(negedge i_clk);

    // Best-case latency: both words queued, consumer ready.
    push_pair(34'h3FFFFFFFF, {22'h2AAAAA, 12'h000}, 56'hFFFFFFFFEAAAAA);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_data_wr && n < 20);
    check("t1_latency", 64'(n), 64'd5);
    check("t1_data", 64'(o_data), 64'hFFFFFFFFEAAAAA);
    repeat (2) @(negedge i_clk);
    check("t1_word_cnt", 64'(o_word_cnt), 64'd1);
    check("t1_err_pad_seen", 64'(errpad_seen), 64'd0);
    check("t1_rd_pulses", 64'(rd_seen), 64'd2);

    // Part 2 arrives late; the FSM must hold without popping.
    base_rd = rd_seen;
    base_wr = wr_seen;
    push_word(34'h1_2345_6789);
    repeat (12) @(negedge i_clk);
    check("t2_rd_while_waiting", 64'(rd_seen - base_rd), 64'd1);
    check("t2_no_wr_while_waiting", 64'(wr_seen - base_wr), 64'd0);
    push_word({22'h3C0FFE, 12'h000});
    exp_q.push_back({34'h1_2345_6789, 22'h3C0FFE});
    words_exp++;
    wait_wr("t2_wr_timeout", base_wr + 1, 30);
    repeat (2) @(negedge i_clk);
    check("t2_rd_total", 64'(rd_seen - base_rd), 64'd2);

    // Consumer not ready for 7 cycles after the pair is read.
    base_wr    = wr_seen;
    i_data_rdy = 1'b0;
    push_pair(34'h0_A5A5_A5A5, {22'h12_3456, 12'h000}, {34'h0_A5A5_A5A5, 22'h12_3456});
    repeat (5) @(negedge i_clk);
    check("t3_data_captured", 64'(o_data), 64'({34'h0_A5A5_A5A5, 22'h12_3456}));
    hold_bad = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge i_clk);
      if (o_data_wr || o_data !== {34'h0_A5A5_A5A5, 22'h12_3456}) hold_bad++;
    end
    check("t3_hold_while_not_ready", 64'(hold_bad), 64'd0);
    i_data_rdy = 1'b1;
    @(posedge i_clk);
    #1;
    i_data_rdy = 1'b0;  // dropped while in S_WRITE: must not matter
    wait_wr("t3_wr_timeout", base_wr + 1, 10);
    i_data_rdy = 1'b1;
    repeat (2) @(negedge i_clk);
    check("t3_single_wr", 64'(wr_seen - base_wr), 64'd1);

    // Pad error: word still delivered, pulse and count.
    base_wr = wr_seen;
    base_ep = errpad_seen;
    push_pair(34'h0_1234_5678, {22'h15_5555, 12'h001}, {34'h0_1234_5678, 22'h15_5555});
    wait_wr("t4_wr_timeout", base_wr + 1, 20);
    repeat (2) @(negedge i_clk);
    check("t4_err_pad_pulses", 64'(errpad_seen - base_ep), 64'd1);
    check("t4_err_cnt", 64'(o_err_cnt), 64'd1);

    // 299 more bad pads: counter saturates at 255, pulses continue.
    for (int k = 0; k < 299; k++) begin
      p1  = {2'($urandom_range(0, 3)), 32'($urandom())};
      mid = 22'($urandom());
      pad = 12'($urandom_range(1, 4095));
      push_pair(p1, {mid, pad}, {p1, mid});
    end
    wait_wr("t4_burst_timeout", base_wr + 300, 299 * 6 + 60);
    repeat (2) @(negedge i_clk);
    check("t4_err_cnt_sat", 64'(o_err_cnt), 64'd255);
    check("t4_err_pad_total", 64'(errpad_seen - base_ep), 64'd300);
    check("t4_word_cnt", 64'(o_word_cnt), 64'(words_exp));

    // Reset while waiting for part 2: outputs clear without a clock edge.
    base_rd = rd_seen;
    push_word(34'h2_DEAD_BEEF);
    repeat (3) @(negedge i_clk);
    check("t5_in_wait_part_2", 64'(rd_seen - base_rd), 64'd1);
    #2;
    i_arst = 1'b1;
    #1;
    check_all_zero("t5_async_reset");
    @(negedge i_clk);
    i_arst    = 1'b0;
    words_exp = 0;
    base_wr   = wr_seen;
    @(negedge i_clk);
    push_pair(34'h3_0F0F_0F0F, {22'h0C_C33C, 12'h000}, {34'h3_0F0F_0F0F, 22'h0C_C33C});
    wait_wr("t5_wr_timeout", base_wr + 1, 20);
    repeat (2) @(negedge i_clk);
    check("t5_word_cnt", 64'(o_word_cnt), 64'd1);
    check("t5_err_cnt", 64'(o_err_cnt), 64'd0);

    // Back-to-back pairs: one write every 6 cycles.
    base_rd = rd_seen;
    base_wr = wr_seen;
    last_wr = -1;
    cad_bad = 0;
    cad_en  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      p1  = {2'($urandom_range(0, 3)), 32'($urandom())};
      mid = 22'($urandom());
      push_pair(p1, {mid, 12'h000}, {p1, mid});
    end
    wait_wr("t6_wr_timeout", base_wr + 40, 40 * 6 + 40);
    cad_en = 1'b0;
    repeat (2) @(negedge i_clk);
    check("t6_cadence", 64'(cad_bad), 64'd0);
    check("t6_rd_pulses", 64'(rd_seen - base_rd), 64'd80);
    check("t6_word_cnt", 64'(o_word_cnt), 64'(words_exp));
    check("t6_fifo_drained", 64'(fifo.size()), 64'd0);
    check("t6_sb_drained", 64'(exp_q.size()), 64'd0);

    // Counter wrap/saturate at a small width: 17 increments.
    cnt_inc = 1'b1;
    repeat (17) @(negedge i_clk);
    cnt_inc = 1'b0;
    @(negedge i_clk);
    check("cnt_wrap", 64'(wrap_cnt), 64'd1);
    check("cnt_saturate", 64'(sat_cnt), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
